// File: rtl/tilebuf_pkg.sv
// tilebuf_pkg: shared types and default geometry for the tile ping-pong buffer.
package tilebuf_pkg;

  typedef enum logic {
    ST_WRITE   = 1'b0,
    ST_PENDING = 1'b1
  } tilebuf_state_e;

  typedef logic bank_sel_t;

  localparam int TILEBUF_DATA_W = 8;
  localparam int TILEBUF_TILE_W = 20;
  localparam int TILEBUF_TILE_H = 20;
  localparam int TILEBUF_COLS   = 32;
  localparam int TILEBUF_ROWS   = 24;

endpackage

// File: rtl/tile_bank_ram.sv
// tile_bank_ram: single-port RAM with synchronous read; one access per cycle.
module tile_bank_ram #(
  parameter int   DEPTH = 768,
  parameter int   WIDTH = 8,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write when enabled with we, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_o       <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/tile_pingpong_buffer.sv
// tile_pingpong_buffer: double-buffered tile map between the game-logic writer
// and the pixel scanout. Banks swap only at a frame origin after a commit.
// Optional build macro TILEBUF_AUTO_SWAP_EN: swap at every frame origin and
// ignore wr_commit.
//
// state   | meaning
// WRITE   | writer owns the back bank, wr_ready high
// PENDING | frame committed, waiting for the next frame origin to swap
module tile_pingpong_buffer
  import tilebuf_pkg::*;
#(
  parameter int              DATA_W   = TILEBUF_DATA_W,
  parameter int              TILE_W   = TILEBUF_TILE_W,
  parameter int              TILE_H   = TILEBUF_TILE_H,
  parameter int              COLS     = TILEBUF_COLS,
  parameter int              ROWS     = TILEBUF_ROWS,
  parameter int              COORD_W  = 10,
  parameter logic [DATA_W-1:0] BG_VALUE = '0,
  localparam int             DEPTH    = COLS * ROWS,
  localparam int             ADDR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_ready,
  input  logic               wr_commit,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_h,
  input  logic [COORD_W-1:0] rd_v,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               frame_start,
  output logic               swap_pending,
  output logic               read_bank
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [COORD_W:0] H_LIM   = (COORD_W+1)'(TILE_W * COLS);
  localparam logic [COORD_W:0] V_LIM   = (COORD_W+1)'(TILE_H * ROWS);

  tilebuf_state_e    state_q;
  bank_sel_t         read_bank_q, read_bank_d;
  logic              wr_ready_q, swap_pending_q, frame_start_q, origin_seen_q;
  logic              fs, swap, off_map, wr_accept;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_v1_q, off_map_q, rd_valid_q;
  bank_sel_t         bank_q1;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] ram_rdata [2];

  assign fs = rd_en && (rd_h == '0) && (rd_v == '0) && !origin_seen_q;

`ifdef TILEBUF_AUTO_SWAP_EN
  assign swap     = fs;
  // Blocking the write in the swap cycle keeps it out of the bank about to be shown.
  assign wr_ready = wr_ready_q && !fs;
`else
  assign swap     = (state_q == ST_PENDING) && fs;
  assign wr_ready = wr_ready_q;
`endif

  // Reads use the post-swap bank so the origin pixel already comes from the new frame.
  assign read_bank_d = read_bank_q ^ swap;
  assign off_map     = ({1'b0, rd_h} >= H_LIM) || ({1'b0, rd_v} >= V_LIM);
  assign rd_idx      = ADDR_W'(rd_h / TILE_W) + ADDR_W'(rd_v / TILE_H) * ADDR_W'(COLS);
  assign wr_accept   = wr_en && wr_ready && ({1'b0, wr_addr} < DEPTH_L);

  // The read bank serves scanout, the other takes writes; writes never
  // coincide with a swap, so the back bank is unambiguous.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic              is_rd;
    logic              en, we;
    logic [ADDR_W-1:0] addr;

    assign is_rd = (read_bank_d == 1'(b));
    assign en    = is_rd ? (rd_en && !off_map) : wr_accept;
    assign we    = !is_rd && wr_accept;
    assign addr  = is_rd ? rd_idx : wr_addr;

    tile_bank_ram #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_ram (
      .clk     (clk),
      .en_i    (en),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wr_data),
      .rdata_o (ram_rdata[b])
    );
  end

  // Origin tracker: one frame start per arrival at (0,0), re-armed by any other pixel.
  always_ff @(posedge clk) begin
    if (rst) origin_seen_q <= 1'b0;
    else if (rd_en) origin_seen_q <= (rd_h == '0) && (rd_v == '0);
  end

  // Commit/swap FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_WRITE;
      read_bank_q    <= 1'b0;
      wr_ready_q     <= 1'b1;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      frame_start_q <= fs;
      read_bank_q   <= read_bank_d;
`ifdef TILEBUF_AUTO_SWAP_EN
      state_q        <= ST_WRITE;
      wr_ready_q     <= 1'b1;
      swap_pending_q <= 1'b0;
`else
      case (state_q)
        ST_WRITE: if (wr_commit) begin
          state_q        <= ST_PENDING;
          wr_ready_q     <= 1'b0;
          swap_pending_q <= 1'b1;
        end
        ST_PENDING: if (fs) begin
          state_q        <= ST_WRITE;
          wr_ready_q     <= 1'b1;
          swap_pending_q <= 1'b0;
        end
      endcase
`endif
    end
  end

  // Two-stage read pipeline: RAM/off-map at t+1, registered data at t+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q    <= 1'b0;
      off_map_q  <= 1'b0;
      bank_q1    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= rd_en;
      off_map_q  <= off_map;
      bank_q1    <= read_bank_d;
      rd_valid_q <= rd_v1_q;
      if (rd_v1_q) rd_data_q <= off_map_q ? BG_VALUE : ram_rdata[bank_q1];
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign frame_start  = frame_start_q;
  assign swap_pending = swap_pending_q;
  assign read_bank    = read_bank_q;

endmodule

// File: tb/tb_tile_pingpong_buffer.sv
// Bench for tile_pingpong_buffer: directed scenarios with literal expectations
// followed by random traffic, all compared every cycle against a frame-level model.
module tb_tile_pingpong_buffer;

  localparam int DEPTH = 768;
  localparam int BG    = 0;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_commit, rd_en;
  logic [9:0] wr_addr, rd_h, rd_v;
  logic [7:0] wr_data;
  logic       wr_ready, rd_valid, frame_start, swap_pending, read_bank;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  tile_pingpong_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_commit(wr_commit),
    .rd_en(rd_en), .rd_h(rd_h), .rd_v(rd_v),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_start(frame_start), .swap_pending(swap_pending), .read_bank(read_bank)
  );

  int checks = 0;
  int errors = 0;

  // Model: two tile arrays, displayed bank, commit flag, origin flag, read delay line.
  logic [7:0] mem [2][DEPTH];
  bit         m_rb = 0, m_pending = 0, m_origin = 0, m_fs = 0, m_ov = 0, m_s1v = 0;
  logic [7:0] m_od = 0, m_s1d = 0;
  logic       last_ready;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("read_bank", 32'(read_bank), 32'(m_rb));
    chk("swap_pending", 32'(swap_pending), 32'(m_pending));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("rd_valid", 32'(rd_valid), 32'(m_ov));
    chk("rd_data", 32'(rd_data), 32'(m_od));
  endtask

  // Inputs are already applied (we are at a negedge); advance one cycle.
  task automatic tick();
    bit fs, rdy, swap, nrb;
    logic [7:0] val;
    #1;
    fs = rd_en && rd_h == 0 && rd_v == 0 && !m_origin;
`ifdef TILEBUF_AUTO_SWAP_EN
    rdy  = !fs;
    swap = fs;
`else
    rdy  = !m_pending;
    swap = m_pending && fs;
`endif
    if (!rst) chk("wr_ready", 32'(wr_ready), 32'(rdy));
    last_ready = wr_ready;
    if (rst) begin
      m_rb = 0; m_pending = 0; m_origin = 0; m_fs = 0;
      m_ov = 0; m_od = 0; m_s1v = 0; m_s1d = 0;
    end else begin
      nrb = m_rb ^ swap;
      if (rd_h >= 640 || rd_v >= 480) val = 8'(BG);
      else val = mem[int'(nrb)][int'(rd_h) / 20 + (int'(rd_v) / 20) * 32];
      if (wr_en && rdy && int'(wr_addr) < DEPTH) mem[int'(!m_rb)][int'(wr_addr)] = wr_data;
      if (m_s1v) m_od = m_s1d;
      m_ov  = m_s1v;
      m_s1v = rd_en;
      m_s1d = val;
      m_fs  = fs;
`ifndef TILEBUF_AUTO_SWAP_EN
      if (m_pending) begin
        if (fs) m_pending = 0;
      end else if (wr_commit) m_pending = 1;
`endif
      m_rb = nrb;
      if (rd_en) m_origin = (rd_h == 0 && rd_v == 0);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
    rd_en = 0; rd_h = 0; rd_v = 0;
  endtask

  task automatic do_idle();
    set_idle(); tick();
  endtask

  task automatic do_rd(int h, int v);
    set_idle(); rd_en = 1; rd_h = 10'(h); rd_v = 10'(v); tick();
  endtask

  task automatic do_wr(int a, int d);
    set_idle(); wr_en = 1; wr_addr = 10'(a); wr_data = 8'(d); tick();
  endtask

  task automatic do_commit();
    set_idle(); wr_commit = 1; tick();
  endtask

  int fcount;

  initial begin
    set_idle();
    rst = 1;
    @(negedge clk);
    tick(); rst = 1; tick();
    chk("reset_wr_ready", 32'(wr_ready), 1);
    chk("reset_read_bank", 32'(read_bank), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_swap_pending", 32'(swap_pending), 0);

    // Fill both banks with zero so every later read has a defined value.
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < DEPTH; a++) do_wr(a, 0);
      do_commit();
      do_rd(0, 0);
      do_rd(1, 0);
    end

`ifndef TILEBUF_AUTO_SWAP_EN
    // Commit a frame with tile 33 = A5 and watch it appear after the origin.
    do_wr(33, 8'hA5);
    do_commit();
    do_rd(20, 20);
    do_idle();
    chk("pre_swap_rd_data", 32'(rd_data), 0);
    chk("pre_swap_pending", 32'(swap_pending), 1);
    chk("pre_swap_wr_ready", 32'(wr_ready), 0);
    do_rd(0, 0);
    chk("swap_read_bank", 32'(read_bank), 1);
    chk("swap_frame_start", 32'(frame_start), 1);
    chk("swap_wr_ready", 32'(wr_ready), 1);
    do_rd(20, 20);
    do_idle();
    chk("post_swap_rd_data", 32'(rd_data), 8'hA5);

    // Commit then two frames with no new commit: a single swap.
    do_commit();
    chk("commit_wr_ready", 32'(wr_ready), 0);
    do_wr(5, 8'h77);
    do_rd(1, 0); do_rd(0, 0);
    chk("one_swap_bank", 32'(read_bank), 0);
    do_rd(1, 0); do_rd(0, 0);
    chk("no_second_swap_bank", 32'(read_bank), 0);
    chk("second_fs_pulse", 32'(frame_start), 1);
    do_rd(100, 0);
    do_idle();
    chk("dropped_write_tile5", 32'(rd_data), 0);

    // Parking on the origin yields a single frame start and a single swap.
    do_rd(1, 0);
    do_commit();
    fcount = 0;
    for (int i = 0; i < 5; i++) begin
      do_rd(0, 0);
      fcount += int'(frame_start);
    end
    chk("parked_fs_count", 32'(fcount), 1);
    chk("parked_read_bank", 32'(read_bank), 1);
    do_rd(1, 0); do_rd(0, 0);
    chk("rearmed_fs", 32'(frame_start), 1);
    chk("rearmed_no_swap", 32'(read_bank), 1);

    // Off-map pixels and an out-of-range write.
    do_rd(20, 20);
    do_rd(640, 0);
    chk("onmap_before_bg", 32'(rd_data), 8'hA5);
    do_rd(0, 480);
    chk("offmap_h", 32'(rd_data), BG);
    do_idle();
    chk("offmap_v", 32'(rd_data), BG);
    do_wr(800, 8'h3C);
    do_rd(20, 20);
    do_idle();
    chk("after_oor_write", 32'(rd_data), 8'hA5);
    do_idle();
    chk("rd_valid_drops", 32'(rd_valid), 0);

    // Reset while pending abandons the swap.
    do_commit();
    set_idle(); rst = 1; tick();
    chk("reset_clears_pending", 32'(swap_pending), 0);
    do_rd(1, 0); do_rd(0, 0);
    chk("reset_no_swap", 32'(read_bank), 0);
`else
    // Every frame origin swaps; a write in the swap cycle is refused.
    for (int k = 0; k < 3; k++) begin
      set_idle(); rd_en = 1; rd_h = 0; rd_v = 0;
      if (k == 0) begin wr_en = 1; wr_addr = 10'd7; wr_data = 8'h11; end
      tick();
      if (k == 0) chk("auto_fs_wr_ready", 32'(last_ready), 0);
      chk("auto_toggle", 32'(read_bank), (k % 2 == 0) ? 1 : 0);
      chk("auto_no_pending", 32'(swap_pending), 0);
      do_rd(1, 0);
    end
`endif

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      set_idle();
      if ($urandom_range(199) == 0) rst = 1;
      else begin
        wr_en     = ($urandom_range(1) == 1);
        wr_addr   = 10'($urandom_range(1023));
        wr_data   = 8'($urandom);
        wr_commit = ($urandom_range(29) == 0);
        rd_en     = ($urandom_range(9) < 7);
        case ($urandom_range(7))
          0, 1:    begin rd_h = 0; rd_v = 0; end
          2:       begin rd_h = 1; rd_v = 0; end
          default: begin rd_h = 10'($urandom_range(700)); rd_v = 10'($urandom_range(520)); end
        endcase
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
